uart_transmitter: RTL and testbench

8N1 UART serializer: accepts one byte per ready/valid handshake and shifts it out LSB-first as start bit, 8 data bits and stop bit. It serves as the RV32I system's UART TX path. In simulation the same block drives the system's UART_RXD pin, so C tests can feed console input to the CPU. Baud timing comes from an integer clocks-per-bit counter; there is no FIFO, so upstream buffering is the producer's job.

---
 rtl/uart_transmitter.sv | 117 +++++++++++
 tb/tb_uart_transmitter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// 8N1 UART serializer: one byte per ready/valid handshake, shifted out LSB-first
// as start bit, eight data bits and stop bit, with integer clocks-per-bit timing.
module uart_transmitter #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int CPB   = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

  generate
    if (CPB < 2) begin : g_cpb_check
      $error("uart_transmitter: CLOCK_FREQ / BAUD_RATE must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_idx;
  logic [9:0]       frame;
  logic             line_q;
  logic             accept;
  logic             bit_done;

  function automatic logic [9:0] build_frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Stop bit is the MSB, so shifting in ones leaves the frame idle-high when done.
  function automatic logic [9:0] shift_frame(input logic [9:0] f);
    return {1'b1, f[9:1]};
  endfunction

  assign accept   = data_in_valid && data_in_ready;
  assign bit_done = (state != IDLE) && (baud_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   if (bit_done) state_nxt = DATA;
      DATA:    if (bit_done && (bit_idx == 4'd8)) state_nxt = STOP;
      STOP:    if (bit_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready decodes registered state only; valid never reaches it combinationally.
  always_comb begin
    data_in_ready = (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
    end else if (state == IDLE) begin
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
    end else if (bit_done) begin
      baud_cnt <= '0;
      bit_idx  <= (state == STOP) ? 4'd0 : bit_idx + 4'd1;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame <= 10'h3FF;
    end else if (accept) begin
      frame <= build_frame(data_in);
    end else if (bit_done) begin
      frame <= shift_frame(frame);
    end
  end

  // The line flop is loaded with the bit that becomes current after this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= 1'b1;
    end else if (accept) begin
      line_q <= 1'b0;
    end else if (state == IDLE) begin
      line_q <= 1'b1;
    end else if (bit_done) begin
      line_q <= (state == STOP) ? 1'b1 : frame[1];
    end
  end

  assign serial_out = line_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: frame-level reference model checked every cycle,
// a mid-bit sampling receiver, and directed scenarios with literal expectations.
module tb_uart_transmitter;

  localparam int CLOCK_FREQ = 50_000_000;
  localparam int BAUD_RATE  = 1_000_000;
  localparam int CPB        = CLOCK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;

  uart_transmitter #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out)
  );

  always #10 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame occupies the 10*CPB cycles after its handshake edge.
  int         cyc   = 0;
  int         t0    = 0;
  bit         mbusy = 1'b0;
  logic [7:0] mbyte = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbusy <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (data_in_valid && !mbusy) begin
        t0    <= cyc + 1;
        mbusy <= 1'b1;
        mbyte <= data_in;
      end else if (mbusy && (cyc + 1 - t0) == 10 * CPB) begin
        mbusy <= 1'b0;
      end
    end
  end

  function automatic logic exp_line(input int c, input logic [7:0] b);
    int k;
    k = (c - 1) / CPB;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (mbusy) begin
        check("model_line", serial_out, exp_line(cyc - t0 + 1, mbyte));
        check("model_ready", data_in_ready, 1'b0);
      end else begin
        check("model_line", serial_out, 1'b1);
        check("model_ready", data_in_ready, 1'b1);
      end
    end
  end

  // Receiver sampling each bit at its middle, counted from the first low cycle.
  bit         rx_on  = 1'b0;
  int         rx_pos = 0;
  logic [7:0] rx_sh  = 8'h00;
  logic [7:0] rxq[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_on <= 1'b0;
    end else if (!rx_on) begin
      if (chk_en && serial_out == 1'b0) begin
        rx_on  <= 1'b1;
        rx_pos <= 1;
      end
    end else begin
      rx_pos <= rx_pos + 1;
      if ((rx_pos + 1) % CPB == CPB / 2) begin
        if ((rx_pos + 1) / CPB == 0) begin
          check("rx_start", serial_out, 1'b0);
        end else if ((rx_pos + 1) / CPB <= 8) begin
          rx_sh[(rx_pos + 1) / CPB - 1] <= serial_out;
        end else begin
          check("rx_stop", serial_out, 1'b1);
          rxq.push_back(rx_sh);
          rx_on <= 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!data_in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", data_in_ready, 1'b1);
    data_in       = b;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  task automatic expect_rx(input string name, input int n,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] exp[3];
    exp[0] = b0;
    exp[1] = b1;
    exp[2] = b2;
    check({name, "_count"}, rxq.size(), n);
    for (int i = 0; i < n && i < rxq.size(); i++)
      check({name, "_byte"}, rxq[i], exp[i]);
    rxq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int         lowcnt;
    int         rdy_lo;
    logic [9:0] pat55;

    // Reset held for 10 cycles, then a long idle stretch.
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("rst_line", serial_out, 1'b1);
      check("rst_ready", data_in_ready, 1'b1);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    lowcnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (serial_out == 1'b0) lowcnt++;
    end
    check("idle_low_cycles", lowcnt, 0);
    check("idle_ready", data_in_ready, 1'b1);

    // Single byte 0x55: mid-bit pattern and ready-low duration.
    pat55 = 10'b1010101010;
    send(8'h55);
    rdy_lo = 0;
    for (int cc = 1; cc <= 520; cc++) begin
      if (cc > 1) @(negedge clk);
      if (!data_in_ready) rdy_lo++;
      if (cc % CPB == CPB / 2 && cc / CPB <= 9)
        check("b55_midbit", serial_out, pat55[cc / CPB]);
    end
    check("b55_ready_low", rdy_lo, 500);
    expect_rx("b55_rx", 1, 8'h55, 8'h00, 8'h00);

    // Back-to-back 0xA3, 0x0F with valid held.
    @(negedge clk);
    data_in       = 8'hA3;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in = 8'h0F;
    for (int cc = 1; cc <= 1100; cc++) begin
      if (cc > 1) @(negedge clk);
      if (cc == 500) check("b2b_ready_500", data_in_ready, 1'b0);
      if (cc == 501) begin
        check("b2b_ready_501", data_in_ready, 1'b1);
        check("b2b_line_501", serial_out, 1'b1);
      end
      if (cc == 502) begin
        check("b2b_ready_502", data_in_ready, 1'b0);
        check("b2b_line_502", serial_out, 1'b0);
        data_in_valid = 1'b0;
      end
    end
    expect_rx("b2b_rx", 2, 8'hA3, 8'h0F, 8'h00);

    // Busy-ignore: valid pulses with 0xFF while 0x00 is on the line.
    send(8'h00);
    lowcnt = 0;
    for (int cc = 1; cc <= 1200; cc++) begin
      if (cc > 1) @(negedge clk);
      if (cc == 100 || cc == 300) begin
        data_in       = 8'hFF;
        data_in_valid = 1'b1;
      end
      if (cc == 101 || cc == 301) data_in_valid = 1'b0;
      if (cc > 500 && serial_out == 1'b0) lowcnt++;
      if (cc == 600) check("busy_ready_600", data_in_ready, 1'b1);
    end
    check("busy_no_second_frame", lowcnt, 0);
    expect_rx("busy_rx", 1, 8'h00, 8'h00, 8'h00);

    // Mid-frame reset during 0x81, then a clean 0x3C.
    send(8'h81);
    for (int cc = 1; cc <= 230; cc++) begin
      if (cc > 1) @(negedge clk);
    end
    check("mid_line_before_rst", serial_out, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_line", serial_out, 1'b1);
    check("mid_rst_ready", data_in_ready, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    expect_rx("mid_abort_rx", 0, 8'h00, 8'h00, 8'h00);
    send(8'h3C);
    for (int cc = 1; cc <= 520; cc++) begin
      if (cc > 1) @(negedge clk);
      if (cc == 1)   check("c3_start_first", serial_out, 1'b0);
      if (cc == 50)  check("c3_start_last", serial_out, 1'b0);
      if (cc == 151) check("c3_d2", serial_out, 1'b1);
      if (cc == 451) check("c3_stop", serial_out, 1'b1);
    end
    expect_rx("c3_rx", 1, 8'h3C, 8'h00, 8'h00);

    // Console string "Hi\n".
    send(8'h48);
    send(8'h69);
    send(8'h0A);
    repeat (520) @(negedge clk);
    expect_rx("hi_rx", 3, 8'h48, 8'h69, 8'h0A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
